fb_write_arbiter: RTL

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Two-requester frame buffer write arbiter: per-requester FIFOs, round-robin pop, registered write port.
// Define FB_WRITE_CLIP_EN to discard out-of-range addresses and count them in drop_count.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 6144,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [15:0]           drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    logic [ADDR_WIDTH-1:0] a_addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] a_data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] b_addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] b_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] a_wr_ptr, a_rd_ptr, b_wr_ptr, b_rd_ptr;
    logic             ready_en;
    grant_t           last_grant;

    logic a_empty, a_full, b_empty, b_full;
    logic a_push, b_push, pop_a, pop_b, pop_any;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic [DATA_WIDTH-1:0] pop_data;

    // ready_en keeps both ready outputs low until the first edge after reset release
    always_comb begin
        a_empty  = (a_wr_ptr == a_rd_ptr);
        b_empty  = (b_wr_ptr == b_rd_ptr);
        a_full   = (a_wr_ptr[PTR_W-1] != a_rd_ptr[PTR_W-1]) &&
                   (a_wr_ptr[IDX_W-1:0] == a_rd_ptr[IDX_W-1:0]);
        b_full   = (b_wr_ptr[PTR_W-1] != b_rd_ptr[PTR_W-1]) &&
                   (b_wr_ptr[IDX_W-1:0] == b_rd_ptr[IDX_W-1:0]);
        a_ready  = ready_en && !a_full;
        b_ready  = ready_en && !b_full;
        a_push   = a_valid && a_ready;
        b_push   = b_valid && b_ready;
        pop_a    = !a_empty && (b_empty || last_grant == GRANT_B);
        pop_b    = !b_empty && !pop_a;
        pop_any  = pop_a || pop_b;
        pop_addr = pop_a ? a_addr_mem[a_rd_ptr[IDX_W-1:0]] : b_addr_mem[b_rd_ptr[IDX_W-1:0]];
        pop_data = pop_a ? a_data_mem[a_rd_ptr[IDX_W-1:0]] : b_data_mem[b_rd_ptr[IDX_W-1:0]];
    end

`ifdef FB_WRITE_CLIP_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_BYTES);
    logic pop_clipped;
    always_comb pop_clipped = (32'(pop_addr) >= ADDR_LIMIT);
`endif

    always_ff @(posedge clk) begin
        if (a_push) begin
            a_addr_mem[a_wr_ptr[IDX_W-1:0]] <= a_addr;
            a_data_mem[a_wr_ptr[IDX_W-1:0]] <= a_data;
        end
        if (b_push) begin
            b_addr_mem[b_wr_ptr[IDX_W-1:0]] <= b_addr;
            b_data_mem[b_wr_ptr[IDX_W-1:0]] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_wr_ptr   <= '0;
            a_rd_ptr   <= '0;
            b_wr_ptr   <= '0;
            b_rd_ptr   <= '0;
            ready_en   <= 1'b0;
            last_grant <= GRANT_B;
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            drop_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (a_push) a_wr_ptr <= a_wr_ptr + PTR_W'(1);
            if (b_push) b_wr_ptr <= b_wr_ptr + PTR_W'(1);
            if (pop_a) begin
                a_rd_ptr   <= a_rd_ptr + PTR_W'(1);
                last_grant <= GRANT_A;
            end else if (pop_b) begin
                b_rd_ptr   <= b_rd_ptr + PTR_W'(1);
                last_grant <= GRANT_B;
            end
`ifdef FB_WRITE_CLIP_EN
            // clipped entries are still consumed; write port keeps its last address/data
            if (pop_any && pop_clipped) begin
                wr_enable <= 1'b0;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (pop_any) begin
                wr_enable <= 1'b1;
                wr_addr   <= pop_addr;
                wr_data   <= pop_data;
            end else begin
                wr_enable <= 1'b0;
            end
`else
            wr_enable <= pop_any;
            if (pop_any) begin
                wr_addr <= pop_addr;
                wr_data <= pop_data;
            end
`endif
        end
    end

endmodule
